pp_accum: RTL

PP_ACCUM -- requirements
Module: pp_accum

---
 rtl/pp_accum.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/pp_accum.sv
// pp_accum: serial accumulator for Booth radix-4 partial products.
// One 33-bit partial product arrives per beat. Beat i is sign-extended
// using pp_e, gets the pp_neg correction added, is weighted by 4^i and is
// summed into a 64-bit accumulator. After N_PP beats the product is offered
// on a valid/ready output port and held until downstream accepts it.

// Runtime invariants of pp_accum, kept apart from the datapath.
module pp_accum_chk #(
  parameter int N_PP = 16
) (
  input logic        clk,
  input logic        rst_n,
  input logic        clr,
  input logic        in_ready,
  input logic        out_valid,
  input logic        out_ready,
  input logic [63:0] product,
  input logic [3:0]  cnt
);

  localparam logic [3:0] LAST_IDX = 4'(N_PP - 1);

  // in_ready and out_valid are complementary views of the DONE state
  a_ready_vs_valid : assert property (@(posedge clk) disable iff (!rst_n)
    in_ready != out_valid);

  // an offered product must not move while downstream stalls
  a_product_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready && !clr) |=> $stable(product));

  // the beat index never runs past the last partial product
  a_cnt_range : assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= LAST_IDX);

endmodule

module pp_accum #(
  parameter int N_PP = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [32:0] pp_data,
  input  logic        pp_e,
  input  logic        pp_neg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product,
  output logic        sign_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(N_PP - 1);

  // Extend a partial product with ~e, add the +1 correction and weight it
  // by 4^idx. Everything wraps modulo 2^64.
  function automatic logic [63:0] build_term(
    input logic [32:0] pp,
    input logic        e,
    input logic        neg,
    input logic [3:0]  idx
  );
    logic [63:0] ext;
    ext = {{31{~e}}, pp} + {63'd0, neg};
    return ext << {idx, 1'b0};
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_s;
  logic [63:0] acc_r;
  logic [63:0] acc_s;
  logic        out_valid_r;
  logic        out_valid_s;
  logic        in_ready_r;
  logic        in_ready_s;
  logic        sign_err_r;
  logic        sign_err_s;

  logic        accept_s;
  logic        out_hs_s;
  logic        bad_sign_s;

  // Handshake qualifiers. No beat can land in DONE because in_ready_r is low
  // there, so a beat and a product handshake never coincide.
  assign accept_s   = in_valid & in_ready_r;
  assign out_hs_s   = out_valid_r & out_ready;
  assign bad_sign_s = (pp_e == pp_data[32]);

  // Next-state, counter, accumulator and flag logic; clr wins over everything
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    acc_s      = acc_r;
    sign_err_s = sign_err_r;

    if (clr) begin
      state_s    = IDLE;
      cnt_s      = 4'd0;
      acc_s      = 64'd0;
      sign_err_s = 1'b0;
    end else begin
      if (accept_s && bad_sign_s) begin
        sign_err_s = 1'b1;
      end else begin
        sign_err_s = sign_err_r;
      end

      case (state_r)
        IDLE: begin
          if (accept_s) begin
            // beat 0 overwrites whatever the previous operation left behind
            acc_s   = build_term(pp_data, pp_e, pp_neg, 4'd0);
            cnt_s   = 4'd1;
            state_s = ACCUM;
          end else begin
            acc_s   = acc_r;
            cnt_s   = cnt_r;
            state_s = IDLE;
          end
        end

        ACCUM: begin
          if (accept_s) begin
            acc_s = acc_r + build_term(pp_data, pp_e, pp_neg, cnt_r);
            if (cnt_r == LAST_IDX) begin
              // park the counter on the last index instead of wrapping
              cnt_s   = cnt_r;
              state_s = DONE;
            end else begin
              cnt_s   = cnt_r + 4'd1;
              state_s = ACCUM;
            end
          end else begin
            acc_s   = acc_r;
            cnt_s   = cnt_r;
            state_s = ACCUM;
          end
        end

        DONE: begin
          if (out_hs_s) begin
            cnt_s   = 4'd0;
            state_s = IDLE;
          end else begin
            cnt_s   = cnt_r;
            state_s = DONE;
          end
        end

        default: begin
          state_s = IDLE;
          cnt_s   = 4'd0;
          acc_s   = 64'd0;
        end
      endcase
    end

    out_valid_s = (state_s == DONE);
    in_ready_s  = (state_s != DONE);
  end

  // State and datapath registers; outputs come straight from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      acc_r       <= 64'd0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      sign_err_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      acc_r       <= acc_s;
      out_valid_r <= out_valid_s;
      in_ready_r  <= in_ready_s;
      sign_err_r  <= sign_err_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign product   = acc_r;
  assign sign_err  = sign_err_r;

  pp_accum_chk #(
    .N_PP(N_PP)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_ready (in_ready_r),
    .out_valid(out_valid_r),
    .out_ready(out_ready),
    .product  (acc_r),
    .cnt      (cnt_r)
  );

endmodule
